line_doubler: RTL

//  Converts 15 kHz RGB333 video into 31 kHz video by buffering each input line and replaying it twice at double pixel rate.

---
 rtl/video_pkg.sv | 42 ++++
 rtl/line_buffer_dp.sv | 40 ++++
 rtl/line_doubler.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/video_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : video_pkg                                              |
// | Description : Shared RGB333 pixel width, channel slice helpers,      |
// |               dimming helper and sync polarity for the video path.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package video_pkg;

    // Packed pixel {R[2:0], G[2:0], B[2:0]}
    localparam int PIX_W = 9;

    // Both sync outputs and inputs are active-low
    localparam logic SYNC_ACTIVE = 1'b0;

    typedef logic [PIX_W-1:0] pixel_t;

    function automatic logic [2:0] r3(input pixel_t p);
        return p[8:6];
    endfunction

    function automatic logic [2:0] g3(input pixel_t p);
        return p[5:3];
    endfunction

    function automatic logic [2:0] b3(input pixel_t p);
        return p[2:0];
    endfunction

    // Halve every colour channel (scanline darkening)
    function automatic pixel_t dim_pix(input pixel_t p);
        logic [2:0] w_r;
        logic [2:0] w_g;
        logic [2:0] w_b;
        w_r = r3(p);
        w_g = g3(p);
        w_b = b3(p);
        return {w_r >> 1, w_g >> 1, w_b >> 1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/line_buffer_dp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : line_buffer_dp                                         |
// | Description : Simple dual-port RAM, one write port and one read port |
// |               with a registered output, single clock. Holds both     |
// |               ping-pong banks of the line doubler.                   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module line_buffer_dp #(
    parameter int DEPTH  = 2048,
    parameter int ADDR_W = 11,
    parameter int DATA_W = 9
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    // Write port
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read port, one clock of latency
    always_ff @(posedge clk) begin
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/line_doubler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : line_doubler                                           |
// | Description : 15 kHz to 31 kHz scan doubler for RGB333 video. Each   |
// |               input line is captured into one bank of a ping-pong    |
// |               buffer while the other bank is replayed twice at the   |
// |               doubled pixel rate with regenerated hsync and re-timed |
// |               vsync.                                                 |
// | Options     : SCANLINES_EN - dim every second replayed line          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module line_doubler
    import video_pkg::*;
#(
    parameter int LINE_MAX = 1024,
    parameter int MIN_LINE = 64,
    parameter int HSYNC_W  = 48
) (
    input  logic             clk_peripheral,
    input  logic             reset,
    input  logic             ce_15,
    input  logic             ce_31,
    input  logic [PIX_W-1:0] video_15,
    input  logic             hsync_15_n,
    input  logic             vsync_15_n,
    output logic [PIX_W-1:0] video_31,
    output logic             hsync,
    output logic             vsync
);

    localparam int c_addr_w = $clog2(LINE_MAX);
    localparam int c_len_w  = $clog2(LINE_MAX + 1);
    localparam int c_hs_w   = $clog2(HSYNC_W + 1);
    localparam int c_ram_aw = c_addr_w + 1;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    logic                r_hs_d;
    logic                r_wr_bank;
    logic [c_addr_w-1:0] r_wr_addr;
    logic [c_len_w-1:0]  r_line_len;

    logic                w_hs_fall;
    logic                w_long_enough;
    logic                w_line_start;
    logic                w_wr_en;
    logic [c_len_w-1:0]  w_len_next;

    assign w_hs_fall     = (r_hs_d != SYNC_ACTIVE) && (hsync_15_n == SYNC_ACTIVE);
    assign w_long_enough = (r_wr_addr >= c_addr_w'(MIN_LINE));
    assign w_line_start  = ce_15 && w_hs_fall && w_long_enough;
    // The pixel that carries the hsync edge is not stored
    assign w_wr_en       = ce_15 && !w_hs_fall;
    // wr_addr never exceeds LINE_MAX-1, so +1 is already capped at LINE_MAX
    assign w_len_next    = c_len_w'(r_wr_addr) + c_len_w'(1);

    // Input line capture: address counter, bank swap and length measurement
    always_ff @(posedge clk_peripheral) begin
        if (reset) begin
            r_hs_d     <= ~SYNC_ACTIVE;
            r_wr_bank  <= 1'b0;
            r_wr_addr  <= '0;
            r_line_len <= '0;
        end else if (ce_15) begin
            r_hs_d <= hsync_15_n;
            if (!w_hs_fall) begin
                if (r_wr_addr != c_addr_w'(LINE_MAX - 1)) begin
                    r_wr_addr <= r_wr_addr + c_addr_w'(1);
                end
            end else if (w_long_enough) begin
                r_line_len <= w_len_next;
                r_wr_bank  <= ~r_wr_bank;
                r_wr_addr  <= '0;
            end else begin
                // Short line: treat as an hsync glitch and restart capture
                r_wr_addr <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------
    logic [c_addr_w-1:0] r_rd_addr;
    logic [c_hs_w-1:0]   r_hs_cnt;
    logic                r_pass;
    logic                r_vs;

    logic                w_active;
    logic                w_rd_last;

    assign w_active  = (r_line_len != '0);
    assign w_rd_last = (c_len_w'(r_rd_addr) == (r_line_len - c_len_w'(1)));

    // Replay counter, hsync width counter, pass toggle and vsync re-timing
    always_ff @(posedge clk_peripheral) begin
        if (reset) begin
            r_rd_addr <= '0;
            r_hs_cnt  <= '0;
            r_pass    <= 1'b0;
            r_vs      <= ~SYNC_ACTIVE;
        end else if (w_line_start) begin
            r_rd_addr <= '0;
            r_hs_cnt  <= '0;
            r_pass    <= 1'b0;
            r_vs      <= vsync_15_n;
        end else if (ce_31 && w_active) begin
            if (w_rd_last) begin
                r_rd_addr <= '0;
                r_hs_cnt  <= '0;
                r_pass    <= ~r_pass;
                r_vs      <= vsync_15_n;
            end else begin
                r_rd_addr <= r_rd_addr + c_addr_w'(1);
                if (r_hs_cnt != c_hs_w'(HSYNC_W)) begin
                    r_hs_cnt <= r_hs_cnt + c_hs_w'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Line buffer: write bank = wr_bank, read bank = ~wr_bank
    // ------------------------------------------------------------------
    logic [PIX_W-1:0] w_ram_q;

    line_buffer_dp #(
        .DEPTH  (2 * LINE_MAX),
        .ADDR_W (c_ram_aw),
        .DATA_W (PIX_W)
    ) u_line_buffer_dp (
        .clk       (clk_peripheral),
        .i_wr_en   (w_wr_en),
        .i_wr_addr ({r_wr_bank, r_wr_addr}),
        .i_wr_data (video_15),
        .i_rd_addr ({~r_wr_bank, r_rd_addr}),
        .o_rd_data (w_ram_q)
    );

    // ------------------------------------------------------------------
    // Output shaping, aligned to the RAM read latency
    // ------------------------------------------------------------------
    logic w_hs_low;
    logic r_blank_s1;
    logic r_hsync_s1;
    logic r_vsync_s1;

    // Nothing measured yet means no hsync pulses and black video
    assign w_hs_low = w_active && (r_hs_cnt < c_hs_w'(HSYNC_W));

    // Stage 1: sync and blanking delayed to line up with RAM data
    always_ff @(posedge clk_peripheral) begin
        if (reset) begin
            r_blank_s1 <= 1'b1;
            r_hsync_s1 <= ~SYNC_ACTIVE;
            r_vsync_s1 <= ~SYNC_ACTIVE;
        end else begin
            r_blank_s1 <= !w_active || w_hs_low;
            r_hsync_s1 <= w_hs_low ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_vsync_s1 <= r_vs;
        end
    end

    logic [PIX_W-1:0] w_pix_sel;

`ifdef SCANLINES_EN
    logic r_pass_s1;

    // Pass flag delayed to line up with RAM data
    always_ff @(posedge clk_peripheral) begin
        if (reset) begin
            r_pass_s1 <= 1'b0;
        end else begin
            r_pass_s1 <= r_pass;
        end
    end

    // Second replay of each line is dimmed
    always_comb begin
        w_pix_sel = w_ram_q;
        if (r_pass_s1) begin
            w_pix_sel = dim_pix(w_ram_q);
        end
    end
`else
    // Both replays are identical
    always_comb begin
        w_pix_sel = w_ram_q;
    end
`endif

    // Stage 2: output registers, blanking overrides pixel data
    always_ff @(posedge clk_peripheral) begin
        if (reset) begin
            video_31 <= '0;
            hsync    <= ~SYNC_ACTIVE;
            vsync    <= ~SYNC_ACTIVE;
        end else begin
            video_31 <= r_blank_s1 ? '0 : w_pix_sel;
            hsync    <= r_hsync_s1;
            vsync    <= r_vsync_s1;
        end
    end

endmodule
`default_nettype wire
